// File: rtl/alu_mdu_pkg.sv
// Shared opcode and FSM-state constants for the ALU/MDU slice.
package alu_mdu_pkg;

  localparam logic [3:0] op_add  = 4'd0;
  localparam logic [3:0] op_sub  = 4'd1;
  localparam logic [3:0] op_and  = 4'd2;
  localparam logic [3:0] op_or   = 4'd3;
  localparam logic [3:0] op_slt  = 4'd4;
  localparam logic [3:0] op_sltu = 4'd5;
  localparam logic [3:0] op_xor  = 4'd6;
  localparam logic [3:0] op_sll  = 4'd7;
  localparam logic [3:0] op_srl  = 4'd8;
  localparam logic [3:0] op_sra  = 4'd9;
  localparam logic [3:0] op_mul  = 4'd10;
  localparam logic [3:0] op_mulh = 4'd11;
  localparam logic [3:0] op_div  = 4'd12;
  localparam logic [3:0] op_divu = 4'd13;
  localparam logic [3:0] op_rem  = 4'd14;
  localparam logic [3:0] op_remu = 4'd15;

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_calc = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  function automatic logic is_iter(input logic [3:0] op);
    return op >= op_mul;
  endfunction

  // Ops whose operands are treated as two's-complement by the iterative engine.
  function automatic logic is_signed_md(input logic [3:0] op);
    return (op == op_mul) || (op == op_mulh) || (op == op_div) || (op == op_rem);
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide engine: shift-add or restoring divide on magnitudes, sign fixed on the result.
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_c
);

  logic [WIDTH-1:0]   hi, lo, m, a_keep, hi_n, lo_n, quo, rem;
  logic [3:0]         op_q;
  logic               neg_p, neg_q, neg_r, dz, sa, sb, ge;
  logic [WIDTH:0]     sum, sh;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign sa = is_signed_md(op) && a[WIDTH-1];
  assign sb = is_signed_md(op) && b[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      a_keep <= '0;
      op_q   <= op_add;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (load) begin
      hi     <= '0;
      lo     <= sa ? -a : a;
      m      <= sb ? -b : b;
      a_keep <= a;
      op_q   <= op;
      neg_p  <= sa ^ sb;
      neg_q  <= (sa ^ sb) && (b != '0);
      neg_r  <= sa;
      dz     <= (b == '0);
    end else if (step) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

  // One step: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide.
  always_comb begin
    sum = {1'b0, hi} + {1'b0, m & {WIDTH{lo[0]}}};
    sh  = {hi, lo[WIDTH-1]};
    ge  = sh >= {1'b0, m};
    if ((op_q == op_mul) || (op_q == op_mulh)) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_n = ge ? (sh[WIDTH-1:0] - m) : sh[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end
  end

  // Result reflects the step being taken this cycle so the caller can latch it on the last step.
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_p ? -prod : prod;
    quo    = dz ? {WIDTH{1'b1}} : (neg_q ? -lo_n : lo_n);
    rem    = dz ? a_keep : (neg_r ? -hi_n : hi_n);
    case (op_q)
      op_mul:          res_c = prod_s[WIDTH-1:0];
      op_mulh:         res_c = prod_s[2*WIDTH-1:WIDTH];
      op_div, op_divu: res_c = quo;
      default:         res_c = rem;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// ALU with single-cycle ops and a WIDTH-cycle iterative multiply/divide unit behind a start/done handshake.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Neg,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  logic [1:0]              state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [WIDTH-1:0]        res_n, alu_c, mdu_c;
  logic                    load_c, step_c;
  logic [SW-1:0]           shamt;
  logic signed [WIDTH-1:0] a_s;

  assign shamt = B[SW-1:0];
  assign a_s   = A;
  assign Zero  = (ALUResult == '0);
  assign Neg   = ALUResult[WIDTH-1];

  always_comb begin
    case (ALUOp)
      op_add:  alu_c = A + B;
      op_sub:  alu_c = A - B;
      op_and:  alu_c = A & B;
      op_or:   alu_c = A | B;
      op_slt:  alu_c = WIDTH'($signed(A) < $signed(B));
      op_sltu: alu_c = WIDTH'(A < B);
      op_xor:  alu_c = A ^ B;
      op_sll:  alu_c = A << shamt;
      op_srl:  alu_c = A >> shamt;
      op_sra:  alu_c = a_s >>> shamt;
      default: alu_c = '0;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .load  (load_c),
    .step  (step_c),
    .op    (ALUOp),
    .a     (A),
    .b     (B),
    .res_c (mdu_c)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    res_n   = ALUResult;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state)
      st_idle: begin
        if (start) begin
          if (is_iter(ALUOp)) begin
            state_n = st_calc;
            cnt_n   = '0;
            load_c  = 1'b1;
          end else begin
            state_n = st_done;
            res_n   = alu_c;
          end
        end
      end
      st_calc: begin
        step_c = 1'b1;
        cnt_n  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_n = st_done;
          res_n   = mdu_c;
        end
      end
      st_done: state_n = st_idle;
      default: state_n = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= st_idle;
      cnt       <= '0;
      ALUResult <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ALUResult <= res_n;
      busy      <= (state_n != st_idle);
      done      <= (state_n == st_done);
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized and directed bench for alu_mdu at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start8;
  logic [3:0]  op32, op8;
  logic [31:0] a32, b32, res32;
  logic [7:0]  a8, b8, res8;
  logic        z32, n32, busy32, done32;
  logic        z8, n8, busy8, done8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .ALUOp(op32), .A(a32), .B(b32),
    .ALUResult(res32), .Zero(z32), .Neg(n32), .busy(busy32), .done(done32)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .ALUOp(op8), .A(a8), .B(b8),
    .ALUResult(res8), .Zero(z8), .Neg(n8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on w-bit values held in 64-bit integers.
  function automatic logic [63:0] model(input int w, input logic [3:0] op,
                                        input logic [63:0] a, input logic [63:0] b);
    longint      mask, sa, sb, mn, p;
    logic [63:0] r;
    int          sh;
    mask = (longint'(1) <<< w) - 1;
    mn   = -(longint'(1) <<< (w - 1));
    sa   = longint'(a);
    sb   = longint'(b);
    if (a[w-1]) sa = sa - (longint'(1) <<< w);
    if (b[w-1]) sb = sb - (longint'(1) <<< w);
    sh = int'(b) & (w - 1);
    p  = sa * sb;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = (sa < sb) ? 64'd1 : 64'd0;
      4'd5:  r = (a < b) ? 64'd1 : 64'd0;
      4'd6:  r = a ^ b;
      4'd7:  r = a << sh;
      4'd8:  r = a >> sh;
      4'd9:  r = 64'(sa >>> sh);
      4'd10: r = 64'(p);
      4'd11: r = 64'(p >>> w);
      4'd12: r = (b == 0) ? 64'(mask) : ((sa == mn && sb == -1) ? a : 64'(sa / sb));
      4'd13: r = (b == 0) ? 64'(mask) : a / b;
      4'd14: r = (b == 0) ? a : ((sa == mn && sb == -1) ? 64'd0 : 64'(sa % sb));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r & 64'(mask);
  endfunction

  // Issue one op, measure latency to done, compare result/flags; poke>0 re-asserts start (add) mid-flight.
  task automatic run(input bit w8, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int poke);
    logic [63:0] am, bm, exp, res;
    int          w, lat, explat;
    bit          seen;
    string       tag;
    w      = w8 ? 8 : 32;
    am     = w8 ? {56'd0, a[7:0]} : {32'd0, a};
    bm     = w8 ? {56'd0, b[7:0]} : {32'd0, b};
    exp    = model(w, op, am, bm);
    explat = (op >= 4'd10) ? w + 1 : 1;
    tag    = $sformatf("w%0d op%0d a=%0h b=%0h", w, op, am, bm);
    if (w8) begin start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin start32 = 1'b1; op32 = op; a32 = a; b32 = b; end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      start8  = 1'b0;
      start32 = (!w8 && lat == poke);
      if (start32) begin op32 = 4'd0; a32 = 32'd1; b32 = 32'd1; end
      if (lat == 1) check({tag, " busy"}, 64'(w8 ? busy8 : busy32), 64'd1);
      seen = w8 ? done8 : done32;
    end
    res = w8 ? {56'd0, res8} : {32'd0, res32};
    check({tag, " latency"}, 64'(lat), 64'(explat));
    check({tag, " result"}, res, exp);
    check({tag, " zero"}, 64'(w8 ? z8 : z32), 64'(exp == 0));
    check({tag, " neg"}, 64'(w8 ? n8 : n32), 64'(exp[w-1]));
    @(negedge clk);
    check({tag, " idle"}, 64'({w8 ? busy8 : busy32, w8 ? done8 : done32}), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    int          lat;
    bit          seen;
    rst = 1'b1;
    start32 = 1'b0; start8 = 1'b0;
    op32 = '0; op8 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset result", 64'(res32), 64'd0);
    check("reset flags", 64'({z32, n32, busy32, done32}), 64'b1000);

    run(0, 4'd0,  32'h7FFF_FFFF, 32'd1, 0);
    run(0, 4'd4,  32'hFFFF_FFFF, 32'd1, 0);
    run(0, 4'd5,  32'hFFFF_FFFF, 32'd1, 0);
    run(0, 4'd9,  32'h8000_0000, 32'd4, 0);
    run(0, 4'd11, 32'hFFFF_FFFE, 32'd3, 0);
    run(0, 4'd10, 32'hFFFF_FFFE, 32'd3, 0);
    run(0, 4'd12, 32'hFFFF_FFF9, 32'd2, 0);
    run(0, 4'd14, 32'hFFFF_FFF9, 32'd2, 0);
    run(0, 4'd13, 32'd5, 32'd0, 0);
    run(0, 4'd14, 32'hFFFF_FFF9, 32'd0, 0);
    run(0, 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(0, 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(1, 4'd0,  32'h7F, 32'd1, 0);
    run(1, 4'd10, 32'h10, 32'h10, 0);
    run(1, 4'd11, 32'h10, 32'h10, 0);
    run(1, 4'd11, 32'hFE, 32'h03, 0);

    // Start during a divide must be ignored.
    run(0, 4'd12, 32'd1000, 32'd7, 5);

    // Reset mid-divide aborts without a done pulse.
    start32 = 1'b1; op32 = 4'd12; a32 = 32'd12345; b32 = 32'd3;
    lat = 0; seen = 1'b0;
    while (lat < 45) begin
      @(negedge clk);
      lat++;
      start32 = 1'b0;
      rst = (lat == 10);
      if (done32) seen = 1'b1;
    end
    check("abort no done", 64'(seen), 64'd0);
    check("abort result", 64'(res32), 64'd0);
    check("abort flags", 64'({z32, n32, busy32}), 64'b100);

    // Start coincident with reset is dropped.
    rst = 1'b1; start32 = 1'b1; op32 = 4'd0; a32 = 32'd5; b32 = 32'd5;
    @(negedge clk);
    rst = 1'b0; start32 = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done32 || busy32) seen = 1'b1;
    end
    check("start+rst ignored", 64'(seen), 64'd0);
    check("start+rst result", 64'(res32), 64'd0);

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_0080; rb = 32'hFFFF_FFFF; end
        2: rb = rb & 32'h0000_000F;
        default: ;
      endcase
      run(i % 3 == 2, rop, ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be >= 4.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request pulse; accepted only when busy=0.
REQ-005 Port: ALUOp  input  4  operation code, sampled on accepted start.
REQ-006 Port: A  input  WIDTH  operand A, sampled on accepted start.
REQ-007 Port: B  input  WIDTH  operand B, sampled on accepted start.
REQ-008 Port: ALUResult  output  WIDTH  registered result, held until next accepted start.
REQ-009 Port: Zero  output  1  ALUResult == 0.
REQ-010 Port: Neg  output  1  ALUResult[WIDTH-1].
REQ-011 Port: busy  output  1  high from cycle after accepted start until cycle done is high, inclusive.
REQ-012 Port: done  output  1  one-cycle pulse; ALUResult valid from this cycle.

Function
REQ-013 Opcodes: add=0, sub=1, and=2, or=3, slt=4, sltu=5, xor=6, sll=7, srl=8, sra=9, mul=10, mulh=11, div=12, divu=13, rem=14, remu=15.
REQ-014 Ops 0-9 are single-cycle class; ops 10-15 are iterative class.
REQ-015 FSM states IDLE, CALC, DONE; IDLE->DONE on accepted single-cycle op; IDLE->CALC on accepted iterative op; CALC->DONE after exactly WIDTH iteration cycles; DONE->IDLE unconditionally.
REQ-016 done high exactly in DONE; single-cycle latency: done 1 cycle after accepted start; iterative latency: done WIDTH+1 cycles after accepted start.
REQ-017 start while busy=1 (CALC or DONE) is ignored; no queuing.
REQ-018 Add/sub wrap modulo 2^WIDTH; slt signed compare, sltu unsigned compare, result zero-extended 0/1.
REQ-019 Shifts use B[$clog2(WIDTH)-1:0] as amount; sra replicates A[WIDTH-1].
REQ-020 mul returns low WIDTH bits of product; mulh returns high WIDTH bits of signed x signed 2*WIDTH product.
REQ-021 Iterative engine: one shift-add (mul) or restoring-subtract (div) step per CALC cycle on operand magnitudes; sign fixed by negation in final step.
REQ-022 Divide by zero: div/divu return all ones; rem/remu return A; still take full WIDTH+1 latency.
REQ-023 Signed overflow (A = most-negative, B = -1): div returns A, rem returns 0.
REQ-024 Signed rem takes sign of A; signed div truncates toward zero.
REQ-025 Zero and Neg derived combinationally from ALUResult register only.
REQ-026 Undefined opcodes impossible (4-bit fully decoded); no default-latch behaviour.

Reset
REQ-027 rst=1 at a clock edge forces IDLE, ALUResult=0, busy=0, done=0, iteration counter=0; Zero therefore 1, Neg 0.
REQ-028 rst during CALC or DONE aborts the operation; no done pulse is produced for it.
REQ-029 start coincident with rst is ignored.

Structure
REQ-030 Opcode constants and FSM state encodings SHALL live in shared constants.vh, extending existing op_* names with op_sll, op_srl, op_sra, op_mul, op_mulh, op_div, op_divu, op_rem, op_remu.
REQ-031 Iteration counter width $clog2(WIDTH)+1.
REQ-032 Iterative datapath SHALL be one sub-module, mdu_iter (operands, op, step enable -> hi/lo result), instantiated once; single-cycle ops computed in alu_mdu.

Verification
REQ-033 WIDTH=32: start add A=0x7FFFFFFF B=1 -> done next cycle, ALUResult=0x80000000, Neg=1, Zero=0.
REQ-034 slt A=-1 B=1 -> 1; sltu same operands -> 0; sra A=0x80000000 B=4 -> 0xF8000000.
REQ-035 mulh A=-2 B=3 -> done after 33 cycles, ALUResult=0xFFFFFFFF; mul same -> 0xFFFFFFFA.
REQ-036 div A=-7 B=2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu A=5 B=0 -> 0xFFFFFFFF; div A=0x80000000 B=-1 -> 0x80000000.
REQ-037 Start div, assert start again at cycle 5 with add -> ignored, div result delivered at cycle 33; rst at cycle 10 of another div -> no done, ALUResult=0, Zero=1.
REQ-038 Rerun REQ-033/035 at WIDTH=8 (mul A=0x10 B=0x10 -> 0x00, mulh -> 0x01, latency 9).
